lru_cache_param: RTL
====================

Name: lru_cache_param

Overview:
- Parametrised successor to the single-channel LRU buffer: a fully associative store of DEPTH words of DATA_W bits with true-LRU replacement.
- Uses a per-entry valid bit, a level-sensitive valid/ready input handshake and a registered lookup response carrying hit/miss, slot index and evicted word.
- Adds flush, an occupancy count, saturating hit/miss statistics and a combinational debug read port for board switches and LEDs.

Parameters:
- DATA_W, 16, width of stored words.
- DEPTH, 8, number of entries (≥2, any integer).
- IDX_W, $clog2(DEPTH), slot index width (derived).
- CNT_W, 16, width of hit/miss statistic counters.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  lookup/insert request present
- in_ready  out  1  block can accept; equals !flush
- in_data  in  DATA_W  word to look up / insert
- flush  in  1  invalidate all entries this cycle
- clr_stats  in  1  synchronous clear of hit_cnt/miss_cnt
- rsp_valid  out  1  one-cycle pulse, response for the previous accept
- rsp_hit  out  1  1 = word was present
- rsp_index  out  IDX_W  slot hit or filled
- rsp_evict  out  1  miss replaced a valid entry
- rsp_evict_data  out  DATA_W  word displaced (0 when rsp_evict=0)
- rd_idx  in  IDX_W  debug read slot
- rd_data  out  DATA_W  mem[rd_idx], combinational; 0 if rd_idx≥DEPTH
- rd_vld  out  1  valid bit of rd_idx; 0 if rd_idx≥DEPTH
- occupancy  out  IDX_W+1  count of valid entries
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Reset (rst=0, immediate, no clock needed):
  - All valid bits = 0, all data = 0, age[i] = i.
  - rsp_* = 0, counters = 0, occupancy = 0.
- Accept: in_valid & in_ready at a rising edge. The handshake is level-based: in_valid held high with in_ready=1 gives one accept per cycle, no edge detection.
- Lookup (combinational on current state):
  - Hit: a valid entry equals in_data; if several match, the lowest index wins.
  - Miss, target = lowest-index invalid entry if any exists; otherwise the entry with age == DEPTH-1.
- Update at the accepting edge:
  - mem[target] ← in_data; valid[target] ← 1.
  - age[target] ← 0; every other entry with age < age[target] increments; the rest hold.
  - Ages remain a permutation of 0..DEPTH-1 at all times.
- Response latency is 1 cycle:
  - rsp_valid=1 in the cycle after an accept, otherwise 0.
  - rsp_hit, rsp_index, rsp_evict and rsp_evict_data are registered alongside and hold their last value while rsp_valid=0.
- Back-to-back accepts: a request sees the state written by the previous accept. Same data twice gives miss then hit.
- Flush:
  - Forces in_ready=0, so no accept occurs in that cycle.
  - At the edge: valid bits ← 0, age[i] ← i; data retained; counters unaffected.
  - rsp_valid=0 in the following cycle unless an accept occurred in the flush cycle, which is impossible.
- Statistics:
  - Each accept increments hit_cnt or miss_cnt, saturating at 2^CNT_W-1.
  - clr_stats in the same cycle as an accept: clear wins and that access is not counted.
- occupancy: registered; +1 on a miss into an invalid slot; unchanged on a hit or eviction; 0 after flush or reset.

Decomposition:
- Package lru_pkg holds:
  - Default constants LRU_DATA_W=16, LRU_DEPTH=8, LRU_CNT_W=16.
  - A response struct typedef (hit, index, evict, evict_data).
- Sub-module lru_age_tracker:
  - Owns the age array, victim selection (invalid-first, then oldest) and the age update on touch(idx).
  - The top level keeps data, valid bits, the compare array, counters and response registers.

Test Plan (defaults unless stated):
- Reset release: rst low mid-cycle → outputs zero immediately; after release occupancy=0, rd_data=0 and rd_vld=0 for rd_idx 0..7, in_ready=1.
- Fill: accept 0x0011,0x0022,…,0x0088 → 8 misses, rsp_index 0..7, rsp_evict=0, occupancy=8, miss_cnt=8, hit_cnt=0.
- Hit then evict:
  - After the fill, accept 0x0033 → rsp_hit=1, rsp_index=2.
  - Then accept 0x0099 → miss, rsp_index=0, rsp_evict=1, rsp_evict_data=0x0011.
- Level handshake: in_valid high 3 cycles with 0x00AA on an empty cache → rsp_valid high 3 consecutive cycles: miss (idx 0), hit, hit; hit_cnt=2.
- Flush with in_valid=1 → in_ready=0, no rsp_valid next cycle, occupancy=0; then accept 0x0033 → miss at index 0, rsp_evict=0.
- Saturation/clear with CNT_W=4: 20 hits → hit_cnt=15; clr_stats coincident with a hit → hit_cnt=0.

Source files
------------

// File: rtl/lru_pkg.sv
// Shared defaults and the response record for the LRU store.
// Pure types and constants; no logic, no latency.
package lru_pkg;
    localparam int LRU_DATA_W = 16;
    localparam int LRU_DEPTH  = 8;
    localparam int LRU_CNT_W  = 16;
    localparam int LRU_IDX_W  = $clog2(LRU_DEPTH);

    typedef struct packed {
        logic                  hit;
        logic [LRU_IDX_W-1:0]  index;
        logic                  evict;
        logic [LRU_DATA_W-1:0] evict_data;
    } lru_rsp_t;
endpackage

// File: rtl/lru_age_tracker.sv
// True-LRU age permutation with invalid-first victim choice; victim is combinational,
// ages update on the touch edge. No backpressure: the parent never touches and flushes together.
module lru_age_tracker #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_touch,
    input  logic [IDX_W-1:0] i_touch_idx,
    input  logic             i_flush,
    input  logic [DEPTH-1:0] i_valid_vec,
    output logic [IDX_W-1:0] o_victim
);
    logic [IDX_W-1:0] r_age [DEPTH];
    logic             w_found;

    always_comb begin
        o_victim = '0;
        w_found  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!i_valid_vec[i] && !w_found) begin
                o_victim = IDX_W'(i);
                w_found  = 1'b1;
            end
        end
        if (!w_found) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_age[i] == IDX_W'(DEPTH-1))
                    o_victim = IDX_W'(i);
            end
        end
    end

    // Touched entry becomes youngest; only entries younger than it age by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_age[i] <= IDX_W'(i);
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++)
                r_age[i] <= IDX_W'(i);
        end else if (i_touch) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IDX_W'(i) == i_touch_idx)
                    r_age[i] <= '0;
                else if (r_age[i] < r_age[i_touch_idx])
                    r_age[i] <= r_age[i] + IDX_W'(1);
            end
        end
    end
endmodule

// File: rtl/lru_cache_param.sv
// Fully associative DEPTH-word store with true-LRU replacement, flush and statistics.
// Response one cycle after accept; in_ready drops only during flush.
module lru_cache_param
    import lru_pkg::*;
#(
    parameter int DATA_W = LRU_DATA_W,
    parameter int DEPTH  = LRU_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int CNT_W  = LRU_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              clr_stats,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_index,
    output logic              rsp_evict,
    output logic [DATA_W-1:0] rsp_evict_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic [IDX_W:0]    occupancy,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    typedef struct packed {
        logic              hit;
        logic [IDX_W-1:0]  index;
        logic              evict;
        logic [DATA_W-1:0] evict_data;
    } rsp_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    rsp_t              r_rsp;
    logic              r_rsp_vld;
    logic [IDX_W:0]    r_occ;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic              w_accept;
    logic              w_hit;
    logic [IDX_W-1:0]  w_hit_idx;
    logic [IDX_W-1:0]  w_victim;
    logic [IDX_W-1:0]  w_target;
    logic              w_evict;

    assign in_ready = !flush;
    assign w_accept = in_valid && in_ready;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (r_valid[i] && r_mem[i] == in_data) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_target = w_hit ? w_hit_idx : w_victim;
    assign w_evict  = !w_hit && r_valid[w_victim];

    lru_age_tracker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_age (
        .clk         (clk),
        .rst         (rst),
        .i_touch     (w_accept),
        .i_touch_idx (w_target),
        .i_flush     (flush),
        .i_valid_vec (r_valid),
        .o_victim    (w_victim)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_valid   <= '0;
            r_rsp     <= '0;
            r_rsp_vld <= 1'b0;
            r_occ     <= '0;
        end else begin
            r_rsp_vld <= w_accept;
            if (flush) begin
                r_valid <= '0;
                r_occ   <= '0;
            end else if (w_accept) begin
                r_mem[w_target]   <= in_data;
                r_valid[w_target] <= 1'b1;
                r_rsp.hit         <= w_hit;
                r_rsp.index       <= w_target;
                r_rsp.evict       <= w_evict;
                r_rsp.evict_data  <= w_evict ? r_mem[w_victim] : '0;
                if (!w_hit && !w_evict)
                    r_occ <= r_occ + (IDX_W+1)'(1);
            end
        end
    end

    // A coincident clear wins, so the access in that cycle goes uncounted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (clr_stats) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept) begin
            if (w_hit && r_hit_cnt != {CNT_W{1'b1}})
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            if (!w_hit && r_miss_cnt != {CNT_W{1'b1}})
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end

    assign rd_data        = (32'(rd_idx) < DEPTH) ? r_mem[rd_idx]   : '0;
    assign rd_vld         = (32'(rd_idx) < DEPTH) ? r_valid[rd_idx] : 1'b0;
    assign rsp_valid      = r_rsp_vld;
    assign rsp_hit        = r_rsp.hit;
    assign rsp_index      = r_rsp.index;
    assign rsp_evict      = r_rsp.evict;
    assign rsp_evict_data = r_rsp.evict_data;
    assign occupancy      = r_occ;
    assign hit_cnt        = r_hit_cnt;
    assign miss_cnt       = r_miss_cnt;
endmodule
